// File: rtl/lsu_mem_responder.sv
// Word-organised data memory for the LSU with a fixed-latency response.
// A single request is captured, held for WAIT_CYCLES wait states, then acknowledged.
module lsu_mem_responder #(
  parameter int DEPTH_WORDS = 2048,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_ld_data,
  output logic        o_ack,
  output logic        o_err,
  output logic        o_busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              sel, req, req_err, capture, commit;
  logic [IDX_W-1:0]  req_idx, idx_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       data_q, rd_word_q, wdata, ext_data;
  logic [2:0]        f3_q;
  logic              store_q, err_q;
  logic [3:0]        be;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       mem [DEPTH_WORDS];
  logic              unused_addr_bits;

  assign unused_addr_bits = ^i_lsu_addr[31:16];

  assign sel     = (i_lsu_addr[15:13] == 3'b001);
  assign req     = sel && (i_lsu_wren || i_lsu_rden);
  assign req_idx = IDX_W'(32'(i_lsu_addr[12:2]) % 32'(DEPTH_WORDS));

  always_comb begin
    req_err = 1'b0;
    case (i_funct3)
      3'd0, 3'd4: req_err = 1'b0;
      3'd1, 3'd5: req_err = i_lsu_addr[0];
      3'd2:       req_err = |i_lsu_addr[1:0];
      default:    req_err = 1'b1;
    endcase
    if (i_lsu_wren && i_lsu_rden) req_err = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          capture   = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == 4'(WAIT_CYCLES - 1)) state_nxt = RESP;
        else                            cnt_nxt   = cnt + 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request fields are kept for the whole transaction; they need no reset.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      idx_q     <= req_idx;
      addr_lo_q <= i_lsu_addr[1:0];
      data_q    <= i_st_data;
      f3_q      <= i_funct3;
      store_q   <= i_lsu_wren;
      err_q     <= req_err;
    end
  end

  always_comb begin
    be    = 4'b1111;
    wdata = data_q;
    case (f3_q[1:0])
      2'd0: begin
        be    = 4'b0001 << addr_lo_q;
        wdata = {4{data_q[7:0]}};
      end
      2'd1: begin
        be    = addr_lo_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = data_q;
      end
    endcase
  end

  assign commit = (state == RESP) && store_q && !err_q && !i_rst;

  // Nothing else can touch the array while a request is outstanding, so the
  // word can be read at capture time and held until the response.
  always_ff @(posedge i_clk) begin
    if (capture) rd_word_q <= mem[req_idx];
    if (commit) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx_q][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    byte_v = rd_word_q[{addr_lo_q, 3'b000} +: 8];
    half_v = addr_lo_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (f3_q)
      3'd0:    ext_data = {{24{byte_v[7]}}, byte_v};
      3'd4:    ext_data = {24'd0, byte_v};
      3'd1:    ext_data = {{16{half_v[15]}}, half_v};
      3'd5:    ext_data = {16'd0, half_v};
      default: ext_data = rd_word_q;
    endcase
  end

  assign o_ack     = (state == RESP) && !i_rst;
  assign o_err     = o_ack && err_q;
  assign o_busy    = (state != IDLE) && !i_rst;
  assign o_ld_data = (o_ack && !store_q && !err_q) ? ext_data : 32'd0;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever o_ack is seen.
module tb_lsu_mem_responder;

  localparam int WAIT_CYCLES = 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic        i_lsu_wren;
  logic        i_lsu_rden;
  logic [2:0]  i_funct3;
  logic [31:0] o_ld_data;
  logic        o_ack;
  logic        o_err;
  logic        o_busy;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          req_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ack_count = 0;
  int   accepted = 0;

  lsu_mem_responder #(.DEPTH_WORDS(2048), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_lsu_addr(i_lsu_addr),
    .i_st_data (i_st_data),
    .i_lsu_wren(i_lsu_wren),
    .i_lsu_rden(i_lsu_rden),
    .i_funct3  (i_funct3),
    .o_ld_data (o_ld_data),
    .o_ack     (o_ack),
    .o_err     (o_err),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every acknowledge must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_ack === 1'b1) begin
      ack_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ack: got ack with err=%0b data=0x%08h, expected no ack (cycle %0d)",
                 o_err, o_ld_data, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("ack_err", 32'(o_err), 32'(e.err));
        checkOutput("ld_data", o_ld_data, e.data);
        checkOutput("latency", 32'(cyc - e.req_cyc), 32'(WAIT_CYCLES + 1));
      end
    end else if (i_rst === 1'b0) begin
      checkOutput("quiet_outputs", o_ld_data | 32'(o_err), 32'd0);
    end
  end

  task automatic waitIdle();
    int n = 0;
    while ((sb.size() != 0 || o_busy !== 1'b0) && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got busy=%0b pending=%0d, expected idle within 20 cycles", o_busy, sb.size());
    end
  endtask

  task automatic driveReq(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] f3);
    i_lsu_wren = wr;
    i_lsu_rden = rd;
    i_lsu_addr = addr;
    i_st_data  = data;
    i_funct3   = f3;
  endtask

  task automatic clearReq();
    driveReq(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
  endtask

  // One accepted request, held for a single sampling edge; expected response queued.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] data, input logic [2:0] f3,
                               input logic exp_err, input logic [31:0] exp_data);
    driveReq(wr, rd, addr, data, f3);
    sb.push_back('{exp_err, exp_data, cyc});
    accepted++;
    @(posedge i_clk);
    @(negedge i_clk);
    clearReq();
    waitIdle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst = 1'b1;
    clearReq();
    repeat (3) @(negedge i_clk);
    checkOutput("rst_ack",  32'(o_ack),  32'd0);
    checkOutput("rst_err",  32'(o_err),  32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_data", o_ld_data,   32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    applyStimulus(1, 0, 32'h2000, 32'h8765_4321, 3'd2, 0, 32'h0);
    applyStimulus(0, 1, 32'h2000, 32'h0, 3'd2, 0, 32'h8765_4321);
    applyStimulus(0, 1, 32'h2003, 32'h0, 3'd0, 0, 32'hFFFF_FF87);
    applyStimulus(0, 1, 32'h2003, 32'h0, 3'd4, 0, 32'h0000_0087);
    applyStimulus(0, 1, 32'h2002, 32'h0, 3'd1, 0, 32'hFFFF_8765);
    applyStimulus(0, 1, 32'h2000, 32'h0, 3'd5, 0, 32'h0000_4321);

    applyStimulus(1, 0, 32'h2001, 32'h0000_00AB, 3'd0, 0, 32'h0);
    applyStimulus(0, 1, 32'h2000, 32'h0, 3'd2, 0, 32'h8765_AB21);
    applyStimulus(0, 1, 32'h2001, 32'h0, 3'd0, 0, 32'hFFFF_FFAB);

    applyStimulus(1, 0, 32'h2002, 32'hFFFF_FFFF, 3'd2, 1, 32'h0);
    applyStimulus(0, 1, 32'h2001, 32'h0, 3'd1, 1, 32'h0);
    applyStimulus(0, 1, 32'h2000, 32'h0, 3'd3, 1, 32'h0);
    applyStimulus(1, 1, 32'h2000, 32'h0000_0000, 3'd2, 1, 32'h0);
    applyStimulus(0, 1, 32'h2000, 32'h0, 3'd2, 0, 32'h8765_AB21);

    applyStimulus(1, 0, 32'h2004, 32'hCAFE_F00D, 3'd2, 0, 32'h0);
    applyStimulus(1, 0, 32'h2006, 32'h1234_BEEF, 3'd1, 0, 32'h0);
    applyStimulus(0, 1, 32'h2006, 32'h0, 3'd5, 0, 32'h0000_BEEF);
    applyStimulus(0, 1, 32'h2004, 32'h0, 3'd2, 0, 32'hBEEF_F00D);

    // Store aborted by a reset pulse during its first wait cycle.
    driveReq(1, 0, 32'h2004, 32'h1111_1111, 3'd2);
    @(posedge i_clk);
    @(negedge i_clk);
    clearReq();
    checkOutput("abort_busy_before", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    checkOutput("abort_busy_after", 32'(o_busy), 32'd0);
    repeat (5) @(negedge i_clk);
    applyStimulus(0, 1, 32'h2004, 32'h0, 3'd2, 0, 32'hBEEF_F00D);

    // Unselected address must not start a transaction.
    driveReq(1, 0, 32'h4000, 32'h5555_5555, 3'd2);
    @(posedge i_clk);
    @(negedge i_clk);
    clearReq();
    checkOutput("unsel_busy", 32'(o_busy), 32'd0);
    repeat (4) @(negedge i_clk);

    // A store presented while busy is dropped; the load ahead of it completes.
    driveReq(0, 1, 32'h2000, 32'h0, 3'd2);
    sb.push_back('{1'b0, 32'h8765_AB21, cyc});
    accepted++;
    @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("busy_in_wait", 32'(o_busy), 32'd1);
    driveReq(1, 0, 32'h2000, 32'h0000_0000, 3'd2);
    repeat (2) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
    clearReq();
    waitIdle();
    applyStimulus(0, 1, 32'h2000, 32'h0, 3'd2, 0, 32'h8765_AB21);

    repeat (3) @(negedge i_clk);
    checkOutput("ack_count", 32'(ack_count), 32'(accepted));
    checkOutput("pending", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
